avalon_readline: RTL and testbench

Memory-side responder for the readline channel. It accepts a held readline request (do + 32-bit address) from the memory-link layer, performs one 4-beat Avalon-MM burst read of the aligned 16-byte line, and assembles the 128-bit line. It returns the line with a single-cycle done pulse. It sits between the cache/link path and the external Avalon memory port.

---
 rtl/avalon_readline_pkg.sv | 35 +++
 rtl/avalon_readline_watchdog.sv | 41 ++++
 rtl/avalon_readline.sv | 154 +++++++++++++++
 tb/tb_avalon_readline.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/avalon_readline_pkg.sv
// Shared ao486 definitions for the readline responder: FSM state encodings,
// burst geometry, watchdog limit and the boolean constants.
package avalon_readline_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  // Readline responder states (2-bit encoding)
  typedef enum logic [1:0] {
    READLINE_IDLE = 2'd0,
    READLINE_CMD  = 2'd1,
    READLINE_DATA = 2'd2,
    READLINE_DONE = 2'd3
  } readline_state_t;

  // Fixed Avalon burst: four 32-bit beats make one 16-byte line
  localparam logic [3:0] READLINE_BURST = 4'd4;

  // Idle DATA cycles tolerated before the watchdog forces completion
  localparam logic [7:0] READLINE_TIMEOUT_MAX = 8'd255;

  // Word value left in line slots that never received a beat
  localparam logic [31:0] READLINE_FILL_WORD = 32'hFFFF_FFFF;

  // Return the line with word slot idx replaced by word
  function automatic logic [127:0] readline_insert(input logic [127:0] line,
                                                   input logic [1:0]   idx,
                                                   input logic [31:0]  word);
    logic [127:0] r;
    r = line;
    r[{idx, 5'd0} +: 32] = word;
    return r;
  endfunction

endpackage

// File: rtl/avalon_readline_watchdog.sv
// Readline watchdog: counts consecutive DATA cycles without a beat and flags
// expiry on the cycle that would complete the allowed number of idle cycles.
// Only built when READLINE_TIMEOUT_EN is defined.
`ifdef READLINE_TIMEOUT_EN
module avalon_readline_watchdog
  import avalon_readline_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic beat,
  output logic expire
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Idle-cycle counter: cleared outside DATA and on every beat, saturating
  always_comb begin
    cnt_d = cnt_q;
    if (!active || beat) begin
      cnt_d = 8'd0;
    end else if (cnt_q != READLINE_TIMEOUT_MAX) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // The current idle cycle is the last one allowed when the count so far is MAX-1
  assign expire = active && !beat && (cnt_q == (READLINE_TIMEOUT_MAX - 8'd1));

  // Counter register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`endif

// File: rtl/avalon_readline.sv
// Readline responder: takes a held readline request, issues one 4-beat
// Avalon-MM burst read of the aligned 16-byte line, assembles the beats and
// returns the line with a one-cycle done pulse.
// Optional feature macro: READLINE_TIMEOUT_EN adds a DATA-phase watchdog that
// fills missing words with all ones and raises the sticky readline_timeout.
module avalon_readline
  import avalon_readline_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         readline_do,
  input  logic [31:0]  readline_address,
  output logic         readline_done,
  output logic [127:0] readline_line,
  output logic [29:0]  avm_address,
  output logic         avm_read,
  output logic [3:0]   avm_burstcount,
  input  logic         avm_waitrequest,
  input  logic [31:0]  avm_readdata,
  input  logic         avm_readdatavalid
`ifdef READLINE_TIMEOUT_EN
  ,
  output logic         readline_timeout
`endif
);

  readline_state_t state_q, state_d;
  logic [1:0]   beat_q, beat_d;
  logic [127:0] asm_q, asm_d;
  logic [127:0] line_q, line_d;
  logic         done_q, done_d;
  logic         read_q, read_d;
  logic [29:0]  addr_q, addr_d;
  logic         timeout_fire;

  // Byte offset within the line never reaches the memory port
  logic unused_addr_bits;
  assign unused_addr_bits = ^readline_address[3:0];

`ifdef READLINE_TIMEOUT_EN
  logic timeout_q, timeout_d;

  avalon_readline_watchdog u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .active (state_q == READLINE_DATA),
    .beat   (avm_readdatavalid),
    .expire (timeout_fire)
  );
`else
  assign timeout_fire = FALSE;
`endif

  // Next-state, command, beat assembly and completion logic
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    asm_d   = asm_q;
    line_d  = line_q;
    done_d  = FALSE;
    read_d  = read_q;
    addr_d  = addr_q;
`ifdef READLINE_TIMEOUT_EN
    timeout_d = timeout_q;
`endif
    case (state_q)
      READLINE_IDLE: begin
        // The request level is only looked at here, so a do still high
        // during the done cycle cannot start a second read.
        if (readline_do) begin
          addr_d  = {readline_address[31:4], 2'b00};
          read_d  = TRUE;
          state_d = READLINE_CMD;
`ifdef READLINE_TIMEOUT_EN
          timeout_d = FALSE;
`endif
        end
      end
      READLINE_CMD: begin
        if (!avm_waitrequest) begin
          read_d  = FALSE;
          beat_d  = 2'd0;
          // Pre-fill so any slot the slave never delivers reads as all ones
          asm_d   = {4{READLINE_FILL_WORD}};
          state_d = READLINE_DATA;
        end
      end
      READLINE_DATA: begin
        if (avm_readdatavalid) begin
          asm_d  = readline_insert(asm_q, beat_q, avm_readdata);
          beat_d = beat_q + 2'd1;
          if (beat_q == 2'd3) begin
            // Publish the finished line together with the done pulse so the
            // visible line only changes on completion.
            line_d  = readline_insert(asm_q, beat_q, avm_readdata);
            done_d  = TRUE;
            state_d = READLINE_DONE;
          end
        end else if (timeout_fire) begin
          line_d  = asm_q;
          beat_d  = 2'd0;
          done_d  = TRUE;
          state_d = READLINE_DONE;
`ifdef READLINE_TIMEOUT_EN
          timeout_d = TRUE;
`endif
        end
      end
      READLINE_DONE: begin
        state_d = READLINE_IDLE;
      end
      default: begin
        state_d = READLINE_IDLE;
      end
    endcase
  end

  // State and output registers; reset also discards any partial line
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= READLINE_IDLE;
      beat_q  <= 2'd0;
      asm_q   <= 128'd0;
      line_q  <= 128'd0;
      done_q  <= FALSE;
      read_q  <= FALSE;
      addr_q  <= 30'd0;
`ifdef READLINE_TIMEOUT_EN
      timeout_q <= FALSE;
`endif
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      asm_q   <= asm_d;
      line_q  <= line_d;
      done_q  <= done_d;
      read_q  <= read_d;
      addr_q  <= addr_d;
`ifdef READLINE_TIMEOUT_EN
      timeout_q <= timeout_d;
`endif
    end
  end

  assign readline_done  = done_q;
  assign readline_line  = line_q;
  assign avm_read       = read_q;
  assign avm_address    = addr_q;
  assign avm_burstcount = READLINE_BURST;
`ifdef READLINE_TIMEOUT_EN
  assign readline_timeout = timeout_q;
`endif

endmodule

// File: tb/tb_avalon_readline.sv
// Bench for avalon_readline: directed scenarios plus randomized transactions
// checked against a transaction-level model of the readline burst.
module tb_avalon_readline;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         readline_do;
  logic [31:0]  readline_address;
  logic         readline_done;
  logic [127:0] readline_line;
  logic [29:0]  avm_address;
  logic         avm_read;
  logic [3:0]   avm_burstcount;
  logic         avm_waitrequest;
  logic [31:0]  avm_readdata;
  logic         avm_readdatavalid;
`ifdef READLINE_TIMEOUT_EN
  logic         readline_timeout;
`endif

  avalon_readline dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .readline_do       (readline_do),
    .readline_address  (readline_address),
    .readline_done     (readline_done),
    .readline_line     (readline_line),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_burstcount    (avm_burstcount),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid)
`ifdef READLINE_TIMEOUT_EN
    ,
    .readline_timeout  (readline_timeout)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int n_issue  = 0;
  int n_done   = 0;
  int exp_issue = 0;
  int exp_done  = 0;
  logic rd_prev = 1'b0;

  logic [127:0] last_line;
  logic [31:0]  words [4];
  int           gap   [4];

  // Count read issues (rising avm_read) and done pulses away from the edge
  always @(negedge clk) begin
    if (avm_read && !rd_prev) n_issue <= n_issue + 1;
    rd_prev <= avm_read;
    if (readline_done) n_done <= n_done + 1;
  end

  initial begin
    #2000000;
    $display("FAIL sim_limit: got time limit reached, expected $finish first");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [127:0] model_line();
    logic [127:0] l;
    l = '0;
    for (int i = 0; i < 4; i++) l = l | (128'(words[i]) << (32 * i));
    return l;
  endfunction

  // One readline request; nbeats < 4 leaves the burst unfinished with do held
  task automatic run_txn(input logic [31:0] addr, input int waits, input int nbeats, input bit spur);
    logic [29:0]  exp_addr;
    logic [127:0] exp_line;
    int           lat;
    exp_addr = 30'(addr / 16 * 4);
    exp_line = model_line();
    if (spur) begin
      avm_readdatavalid = 1'b1;
      avm_readdata      = 32'hDEAD_BEEF;
      step();
      avm_readdatavalid = 1'b0;
      check("spur_idle_line", readline_line, last_line);
      check("spur_idle_read", 128'(avm_read), 128'd0);
    end
    readline_do      = 1'b1;
    readline_address = addr;
    cyc = 0;
    step();
    exp_issue++;
    check("cmd_read", 128'(avm_read), 128'd1);
    check("cmd_addr", 128'(avm_address), 128'(exp_addr));
    check("burstcount", 128'(avm_burstcount), 128'd4);
`ifdef READLINE_TIMEOUT_EN
    check("timeout_clr", 128'(readline_timeout), 128'd0);
`endif
    for (int w = 0; w < waits; w++) begin
      avm_waitrequest = 1'b1;
      step();
      check("stall_read", 128'(avm_read), 128'd1);
      check("stall_addr", 128'(avm_address), 128'(exp_addr));
    end
    avm_waitrequest = 1'b0;
    step();
    check("read_drop", 128'(avm_read), 128'd0);
    lat = 6 + waits;
    for (int b = 0; b < nbeats; b++) begin
      for (int g = 0; g < gap[b]; g++) step();
      lat += gap[b];
      avm_readdatavalid = 1'b1;
      avm_readdata      = words[b];
      step();
      avm_readdatavalid = 1'b0;
      avm_readdata      = $urandom();
      if (b < 3) begin
        check("line_hold", readline_line, last_line);
        check("no_early_done", 128'(readline_done), 128'd0);
      end
    end
    if (nbeats < 4) return;
    check("done_pulse", 128'(readline_done), 128'd1);
    check("done_cycle", 128'(cyc), 128'(lat));
    check("line", readline_line, exp_line);
    last_line = exp_line;
    exp_done++;
    // do stays high through the done cycle; a strobe here must be ignored
    if (spur) begin
      avm_readdatavalid = 1'b1;
      avm_readdata      = 32'hDEAD_BEEF;
    end
    step();
    avm_readdatavalid = 1'b0;
    readline_do = 1'b0;
    check("done_single", 128'(readline_done), 128'd0);
    check("line_keep", readline_line, last_line);
    step();
    check("no_reissue", 128'(avm_read), 128'd0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    readline_do = 1'b0;
    readline_address = 32'd0;
    avm_waitrequest = 1'b0;
    avm_readdata = 32'd0;
    avm_readdatavalid = 1'b0;
    last_line = 128'd0;
    for (int i = 0; i < 4; i++) gap[i] = 0;
    repeat (3) step();
    check("rst_done", 128'(readline_done), 128'd0);
    check("rst_line", readline_line, 128'd0);
    check("rst_read", 128'(avm_read), 128'd0);
    check("rst_addr", 128'(avm_address), 128'd0);
`ifdef READLINE_TIMEOUT_EN
    check("rst_timeout", 128'(readline_timeout), 128'd0);
`endif
    rst_n = 1'b1;
    step();

    // Zero-wait read of the reference line
    words[0] = 32'h1111_1111; words[1] = 32'h2222_2222;
    words[2] = 32'h3333_3333; words[3] = 32'h4444_4444;
    run_txn(32'h0001_2348, 0, 4, 1'b0);
    check("ref_line", readline_line, 128'h44444444_33333333_22222222_11111111);

    // Three waitrequest cycles: done lands at cycle 9
    words[0] = 32'hA0A0_0001; words[1] = 32'hB1B1_0002;
    words[2] = 32'hC2C2_0003; words[3] = 32'hD3D3_0004;
    run_txn(32'h8000_0FF0, 3, 4, 1'b0);

    // Gaps between beats and a spurious strobe in IDLE and DONE
    gap[0] = 2; gap[1] = 1; gap[2] = 3; gap[3] = 1;
    words[0] = 32'h0BAD_F00D; words[1] = 32'h1234_5678;
    words[2] = 32'hFFFF_0000; words[3] = 32'h0000_FFFF;
    run_txn(32'hFFFF_FFFF, 1, 4, 1'b1);
    for (int i = 0; i < 4; i++) gap[i] = 0;

    // Reset after two beats, then a late beat and a fresh request
    words[0] = 32'h5555_5555; words[1] = 32'h6666_6666;
    run_txn(32'h0000_1000, 0, 2, 1'b0);
    rst_n = 1'b0;
    readline_do = 1'b0;
    step();
    check("mid_rst_done", 128'(readline_done), 128'd0);
    check("mid_rst_line", readline_line, 128'd0);
    check("mid_rst_read", 128'(avm_read), 128'd0);
    check("mid_rst_addr", 128'(avm_address), 128'd0);
    last_line = 128'd0;
    rst_n = 1'b1;
    avm_readdatavalid = 1'b1;
    avm_readdata = 32'h7777_7777;
    step();
    avm_readdatavalid = 1'b0;
    check("late_beat_line", readline_line, 128'd0);
    words[0] = 32'h9999_0000; words[1] = 32'h9999_1111;
    words[2] = 32'h9999_2222; words[3] = 32'h9999_3333;
    run_txn(32'h0000_2004, 0, 4, 1'b0);

`ifdef READLINE_TIMEOUT_EN
    // Two beats then silence: watchdog completes with ones in the upper half
    words[0] = 32'hCAFE_0000; words[1] = 32'hCAFE_1111;
    run_txn(32'h0000_3000, 0, 2, 1'b0);
    n = 0;
    while (!readline_done && n < 400) begin
      step();
      n++;
    end
    check("to_done", 128'(readline_done), 128'd1);
    check("to_cycles", 128'(n), 128'd255);
    check("to_line", readline_line, {64'hFFFF_FFFF_FFFF_FFFF, 32'hCAFE_1111, 32'hCAFE_0000});
    check("to_flag", 128'(readline_timeout), 128'd1);
    exp_done++;
    last_line = {64'hFFFF_FFFF_FFFF_FFFF, 32'hCAFE_1111, 32'hCAFE_0000};
    step();
    readline_do = 1'b0;
    check("to_sticky", 128'(readline_timeout), 128'd1);
    step();
`endif

    // Randomized transactions
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < 4; i++) begin
        words[i] = $urandom();
        gap[i]   = $urandom_range(0, 2);
      end
      run_txn($urandom(), $urandom_range(0, 3), 4, 1'($urandom_range(0, 1)));
    end

    step();
    check("issue_count", 128'(n_issue), 128'(exp_issue));
    check("done_count", 128'(n_done), 128'(exp_done));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
